// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 serial receiver; framed bytes strobe out on load, bad stop bits on frame_err.
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] dout,
  output logic       load,
  output logic       frame_err,
  output logic       busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT} state_t;
  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bitcnt;
  logic [7:0]    sr;
  logic          rx_meta, rxs;
  logic          mid, full;
  assign mid  = cnt == CW'(CLKS_PER_BIT / 2 - 1);
  assign full = cnt == CW'(CLKS_PER_BIT - 1);
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rx_meta   <= 1'b1;
      rxs       <= 1'b1;
      state     <= IDLE;
      cnt       <= '0;
      bitcnt    <= '0;
      sr        <= '0;
      dout      <= '0;
      load      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_meta   <= rxd;
      rxs       <= rx_meta;
      load      <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          cnt    <= '0;
          bitcnt <= '0;
          state  <= rxs ? IDLE : START;
        end
        START: begin
          cnt    <= mid ? '0 : cnt + 1'b1;
          bitcnt <= '0;
          state  <= !mid ? START : rxs ? IDLE : DATA;
        end
        DATA: begin
          cnt <= full ? '0 : cnt + 1'b1;
          if (full) begin
            sr[bitcnt] <= rxs;
            bitcnt     <= bitcnt + 1'b1;
            state      <= bitcnt == 3'd7 ? STOP : DATA;
          end
        end
        STOP: begin
          cnt <= full ? '0 : cnt + 1'b1;
          if (full) begin
            dout      <= rxs ? sr : dout;
            load      <= rxs;
            frame_err <= !rxs;
            state     <= rxs ? IDLE : WAIT;
          end
        end
        WAIT: state <= rxs ? IDLE : WAIT;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_rx_byte.sv
// tb_uart_rx_byte: drives 8N1 frames and checks bytes, strobes and timing against a frame-level model.
module tb_uart_rx_byte;
  localparam int N = 16;
  logic clk = 0, reset = 1, rxd = 1;
  logic [7:0] dout;
  logic load, frame_err, busy;
  int n_chk = 0, n_fail = 0;
  int cyc = 0, load_cyc = 0, err_cnt = 0, both_cnt = 0, busy_cnt = 0;
  logic [7:0] load_q[$];

  uart_rx_byte #(.CLKS_PER_BIT(N)) dut (
    .clk(clk), .reset(reset), .rxd(rxd), .dout(dout),
    .load(load), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    #1;
    if (load) begin load_q.push_back(dout); load_cyc = cyc; end
    if (frame_err) err_cnt++;
    if (load && frame_err) both_cnt++;
    if (busy) busy_cnt++;
  end

  task automatic bit_time(input logic v, input int clocks);
    rxd = v;
    repeat (clocks) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input logic stop);
    bit_time(1'b0, N);
    for (int i = 0; i < 8; i++) bit_time(b[i], N);
    bit_time(stop, N);
  endtask

  task automatic clear_obs;
    load_q.delete();
    err_cnt = 0; both_cnt = 0; busy_cnt = 0;
  endtask

  task automatic test_reset;
    #2 reset = 0;
    repeat (3) @(negedge clk);
    n_chk++; if (dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout: got %h expected 00", dout); end
    n_chk++; if (load !== 1'b0) begin n_fail++; $display("FAIL reset_load: got %b expected 0", load); end
    n_chk++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    reset = 1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_single;
    clear_obs();
    send(8'hA5, 1'b1);
    bit_time(1'b1, 20);
    n_chk++; if (load_q.size() != 1) begin n_fail++; $display("FAIL single_count: got %0d expected 1", load_q.size()); end
    n_chk++; if (load_q[0] !== 8'hA5) begin n_fail++; $display("FAIL single_dout: got %h expected a5", load_q[0]); end
    n_chk++; if (err_cnt != 0) begin n_fail++; $display("FAIL single_err: got %0d expected 0", err_cnt); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy: got %b expected 0", busy); end
  endtask

  task automatic test_back_to_back;
    int c1;
    clear_obs();
    send(8'h00, 1'b1);
    c1 = load_cyc;
    send(8'hFF, 1'b1);
    bit_time(1'b1, 20);
    n_chk++; if (load_q.size() != 2) begin n_fail++; $display("FAIL b2b_count: got %0d expected 2", load_q.size()); end
    n_chk++; if (load_q[0] !== 8'h00) begin n_fail++; $display("FAIL b2b_first: got %h expected 00", load_q[0]); end
    n_chk++; if (load_q[1] !== 8'hFF) begin n_fail++; $display("FAIL b2b_second: got %h expected ff", load_q[1]); end
    n_chk++; if (load_cyc - c1 != 10 * N) begin n_fail++; $display("FAIL b2b_spacing: got %0d expected %0d", load_cyc - c1, 10 * N); end
  endtask

  task automatic test_false_start;
    logic [7:0] d0;
    clear_obs();
    d0 = dout;
    bit_time(1'b0, 4);
    bit_time(1'b1, 30);
    n_chk++; if (load_q.size() != 0) begin n_fail++; $display("FAIL false_load: got %0d expected 0", load_q.size()); end
    n_chk++; if (err_cnt != 0) begin n_fail++; $display("FAIL false_err: got %0d expected 0", err_cnt); end
    n_chk++; if (busy_cnt != N / 2) begin n_fail++; $display("FAIL false_busy_len: got %0d expected %0d", busy_cnt, N / 2); end
    n_chk++; if (dout !== d0) begin n_fail++; $display("FAIL false_dout: got %h expected %h", dout, d0); end
  endtask

  task automatic test_frame_err;
    logic [7:0] d0;
    clear_obs();
    d0 = dout;
    send(8'h3C, 1'b0);
    bit_time(1'b0, 40);
    n_chk++; if (err_cnt != 1) begin n_fail++; $display("FAIL ferr_count: got %0d expected 1", err_cnt); end
    n_chk++; if (load_q.size() != 0) begin n_fail++; $display("FAIL ferr_load: got %0d expected 0", load_q.size()); end
    n_chk++; if (dout !== d0) begin n_fail++; $display("FAIL ferr_dout: got %h expected %h", dout, d0); end
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ferr_wait_busy: got %b expected 1", busy); end
    bit_time(1'b1, 20);
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ferr_release_busy: got %b expected 0", busy); end
    send(8'h5A, 1'b1);
    bit_time(1'b1, 20);
    n_chk++; if (load_q.size() != 1) begin n_fail++; $display("FAIL ferr_next_count: got %0d expected 1", load_q.size()); end
    n_chk++; if (load_q[0] !== 8'h5A) begin n_fail++; $display("FAIL ferr_next_dout: got %h expected 5a", load_q[0]); end
    n_chk++; if (err_cnt != 1) begin n_fail++; $display("FAIL ferr_next_err: got %0d expected 1", err_cnt); end
  endtask

  task automatic test_reset_mid;
    logic [7:0] b;
    b = 8'hC3;
    clear_obs();
    bit_time(1'b0, N);
    for (int i = 0; i < 4; i++) bit_time(b[i], N);
    bit_time(b[4], N / 2);
    reset = 0;
    #1;
    n_chk++; if (dout !== 8'h00) begin n_fail++; $display("FAIL rmid_dout: got %h expected 00", dout); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b expected 0", busy); end
    n_chk++; if (load !== 1'b0 || frame_err !== 1'b0) begin n_fail++; $display("FAIL rmid_strobes: got %b%b expected 00", load, frame_err); end
    repeat (3) @(negedge clk);
    rxd = 1;
    reset = 1;
    bit_time(1'b1, 20);
    n_chk++; if (load_q.size() != 0) begin n_fail++; $display("FAIL rmid_no_load: got %0d expected 0", load_q.size()); end
    send(8'h81, 1'b1);
    bit_time(1'b1, 20);
    n_chk++; if (load_q.size() != 1) begin n_fail++; $display("FAIL rmid_next_count: got %0d expected 1", load_q.size()); end
    n_chk++; if (load_q[0] !== 8'h81) begin n_fail++; $display("FAIL rmid_next_dout: got %h expected 81", load_q[0]); end
  endtask

  task automatic test_timing;
    int c0;
    clear_obs();
    c0 = cyc;
    send(8'h55, 1'b1);
    bit_time(1'b1, 10);
    n_chk++; if (load_q.size() != 1) begin n_fail++; $display("FAIL timing_count: got %0d expected 1", load_q.size()); end
    n_chk++; if (load_q[0] !== 8'h55) begin n_fail++; $display("FAIL timing_dout: got %h expected 55", load_q[0]); end
    n_chk++; if (load_cyc - c0 != 2 + 1 + N / 2 + 9 * N) begin n_fail++; $display("FAIL timing_latency: got %0d expected %0d", load_cyc - c0, 2 + 1 + N / 2 + 9 * N); end
  endtask

  task automatic test_random;
    logic [7:0] exp_q[$];
    logic [7:0] b;
    logic good;
    int exp_err, gap;
    clear_obs();
    exp_err = 0;
    for (int f = 0; f < 24; f++) begin
      b = 8'($urandom);
      good = $urandom_range(0, 3) != 0;
      send(b, good);
      if (good) exp_q.push_back(b);
      else exp_err++;
      gap = good ? $urandom_range(0, 20) : $urandom_range(2, 20);
      if (gap > 0) bit_time(1'b1, gap);
    end
    bit_time(1'b1, 20);
    n_chk++; if (load_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rand_count: got %0d expected %0d", load_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_chk++; if (load_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_byte[%0d]: got %h expected %h", i, load_q[i], exp_q[i]); end
    end
    n_chk++; if (err_cnt != exp_err) begin n_fail++; $display("FAIL rand_err: got %0d expected %0d", err_cnt, exp_err); end
    n_chk++; if (both_cnt != 0) begin n_fail++; $display("FAIL rand_exclusive: got %0d expected 0", both_cnt); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_false_start();
    test_frame_err();
    test_reset_mid();
    test_timing();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
